vga_console_ctrl: RTL and testbench

- Text-console sequencer that drives the write side of the VGA text display: wren, wraddr, datain, memop, color_wren and start_line.
- Accepts a byte stream of characters and control codes through a valid/ready handshake.
- Maintains the cursor, issues VRAM writes, and performs hardware scrolling by advancing start_line and blanking the newly exposed ring row.
- Also performs a full-screen clear in hardware, so the CPU only pushes bytes.

---
 rtl/vga_console_if.sv | 32 +++
 rtl/vga_console_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_console_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_console_if.sv
// Character-stream and VRAM-write bundle for the VGA text console sequencer.
//
// master : byte/colour producer (CPU side). It drives char_valid, char_data,
//          color_set and color_val, and observes everything else.
// slave  : the console sequencer. It accepts the byte stream and drives the
//          VRAM write port (wren, wraddr, datain, memop), the colour register
//          strobe (color_wren), the scroll origin (start_line) and the
//          handshake/status flags (char_ready, busy).
interface vga_console_if;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        color_set;
  logic [2:0]  color_val;
  logic        wren;
  logic [31:0] wraddr;
  logic [31:0] datain;
  logic [2:0]  memop;
  logic        color_wren;
  logic [5:0]  start_line;
  logic        busy;

  modport master (
    output char_valid, char_data, color_set, color_val,
    input  char_ready, wren, wraddr, datain, memop, color_wren, start_line, busy
  );

  modport slave (
    input  char_valid, char_data, color_set, color_val,
    output char_ready, wren, wraddr, datain, memop, color_wren, start_line, busy
  );
endinterface

// File: rtl/vga_console_ctrl.sv
// Text-console sequencer for the write side of the VGA text display.
//
// Takes a byte stream (printable characters and control codes) over a
// valid/ready handshake, keeps the cursor, writes characters into the VRAM
// ring, scrolls by advancing start_line and blanking the newly exposed ring
// row, and clears the whole ring in hardware on form feed.
//
// Ports:
//   wrclk  : write clock, everything runs on its rising edge
//   rst_n  : synchronous active-low reset
//   bus    : vga_console_if.slave
//            char_valid/char_data/char_ready : byte stream handshake
//            color_set/color_val             : colour change request
//            wren/wraddr/datain/memop        : VRAM write port (registered)
//            color_wren                      : colour register strobe (registered)
//            start_line                      : ring row shown at screen top
//            busy                            : sequencer not in IDLE
module vga_console_ctrl #(
  parameter int          COLS      = 70,
  parameter int          RING_ROWS = 64,
  parameter int          VIS_ROWS  = 30,
  parameter logic [7:0]  BLANK     = 8'h20
) (
  input  logic           wrclk,
  input  logic           rst_n,
  vga_console_if.slave   bus
);

  localparam int RW    = 6;
  localparam int CW    = $clog2(COLS + 1);
  localparam int WORDS = RING_ROWS * COLS / 4;
  localparam int NW    = $clog2(WORDS + 1);
  localparam int AW    = 13;

  localparam logic [2:0] MEM_BYTE = 3'b000;
  localparam logic [2:0] MEM_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, WR_CHAR, CLR_LINE, CLR_ALL} state_t;
  // What WR_CHAR does to the cursor once its (optional) write is out.
  typedef enum logic [1:0] {OP_NONE, OP_ADV, OP_NL} op_t;

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r,
                                              input logic [CW-1:0] c);
    return AW'(32'(r) * 32'(COLS) + 32'(c));
  endfunction

  function automatic logic [AW-1:0] word_addr(input logic [NW-1:0] n);
    return AW'({n, 2'b00});
  endfunction

  state_t          state_q,  state_d;
  op_t             op_q,     op_d;
  logic [RW-1:0]   row_q,    row_d;
  logic [CW-1:0]   col_q,    col_d;
  logic [RW-1:0]   sl_q,     sl_d;
  logic [RW-1:0]   crow_q,   crow_d;
  logic [NW-1:0]   cnt_q,    cnt_d;
  logic            wren_q,   wren_d;
  logic [AW-1:0]   waddr_q,  waddr_d;
  logic [31:0]     datain_q, datain_d;
  logic [2:0]      memop_q,  memop_d;
  logic            cwren_q,  cwren_d;

  logic [RW-1:0]   row_inc;
  logic            scroll;
  logic            nl;
  logic [7:0]      ch;

  // The next row wraps in 6 bits; it scrolls once it would sit VIS_ROWS
  // below the current top of screen.
  assign row_inc = row_q + RW'(1);
  assign scroll  = (RW'(row_inc - sl_q) == RW'(VIS_ROWS));
  assign nl      = (op_q == OP_NL) || ((op_q == OP_ADV) && (col_q == CW'(COLS - 1)));
  assign ch      = bus.char_data;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    row_d    = row_q;
    col_d    = col_q;
    sl_d     = sl_q;
    crow_d   = crow_q;
    cnt_d    = cnt_q;
    wren_d   = 1'b0;
    waddr_d  = waddr_q;
    datain_d = datain_q;
    memop_d  = memop_q;
    cwren_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.char_valid) begin
          if (ch >= 8'h20 && ch <= 8'h7E) begin
            state_d  = WR_CHAR;
            op_d     = OP_ADV;
            wren_d   = 1'b1;
            memop_d  = MEM_BYTE;
            waddr_d  = cell_addr(row_q, col_q);
            datain_d = {24'b0, ch};
          end else begin
            case (ch)
              8'h0A: begin
                state_d = WR_CHAR;
                op_d    = OP_NL;
              end
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d    = col_q - CW'(1);
                  state_d  = WR_CHAR;
                  op_d     = OP_NONE;
                  wren_d   = 1'b1;
                  memop_d  = MEM_BYTE;
                  waddr_d  = cell_addr(row_q, col_q - CW'(1));
                  datain_d = {24'b0, BLANK};
                end
              end
              8'h0C: begin
                state_d  = CLR_ALL;
                wren_d   = 1'b1;
                memop_d  = MEM_WORD;
                waddr_d  = '0;
                datain_d = {4{BLANK}};
                cnt_d    = NW'(1);
              end
              default: ;
            endcase
          end
        end else if (bus.color_set) begin
          // Colour writes reuse datain; wren stays low this cycle.
          cwren_d  = 1'b1;
          datain_d = {29'b0, bus.color_val};
        end
      end

      WR_CHAR: begin
        state_d = IDLE;
        if (op_q == OP_ADV) col_d = col_q + CW'(1);
        if (nl) begin
          col_d = '0;
          row_d = row_inc;
          if (scroll) begin
            // First blank of the exposed row goes out with the state change.
            sl_d     = sl_q + RW'(1);
            crow_d   = row_inc;
            state_d  = CLR_LINE;
            wren_d   = 1'b1;
            memop_d  = MEM_BYTE;
            waddr_d  = cell_addr(row_inc, '0);
            datain_d = {24'b0, BLANK};
            cnt_d    = NW'(1);
          end
        end
      end

      CLR_LINE: begin
        if (cnt_q == NW'(COLS)) begin
          state_d = IDLE;
        end else begin
          wren_d  = 1'b1;
          waddr_d = cell_addr(crow_q, cnt_q[CW-1:0]);
          cnt_d   = cnt_q + NW'(1);
        end
      end

      CLR_ALL: begin
        if (cnt_q == NW'(WORDS)) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          sl_d    = '0;
        end else begin
          wren_d  = 1'b1;
          waddr_d = word_addr(cnt_q);
          cnt_d   = cnt_q + NW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Register stage: sequencer state and all write-port outputs.
  always_ff @(posedge wrclk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_NONE;
      row_q    <= '0;
      col_q    <= '0;
      sl_q     <= '0;
      crow_q   <= '0;
      cnt_q    <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      datain_q <= '0;
      memop_q  <= MEM_BYTE;
      cwren_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sl_q     <= sl_d;
      crow_q   <= crow_d;
      cnt_q    <= cnt_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      datain_q <= datain_d;
      memop_q  <= memop_d;
      cwren_q  <= cwren_d;
    end
  end

  assign bus.char_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.wren       = wren_q;
  assign bus.wraddr     = 32'(waddr_q);
  assign bus.datain     = datain_q;
  assign bus.memop      = memop_q;
  assign bus.color_wren = cwren_q;
  assign bus.start_line = sl_q;

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl: a cursor/scroll model queues every
// expected VRAM or colour write, and a negedge monitor pops and compares.
module tb_vga_console_ctrl;

  logic wrclk = 1'b0;
  logic rst_n;

  always #5 wrclk = ~wrclk;

  vga_console_if bus();

  vga_console_ctrl dut (
    .wrclk (wrclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_color;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  memop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_row = 0, m_col = 0, m_sl = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_w(input int addr, input logic [31:0] d, input logic [2:0] op);
    exp_t x;
    x.is_color = 1'b0;
    x.addr     = 32'(addr);
    x.data     = d;
    x.memop    = op;
    sb.push_back(x);
  endfunction

  function automatic void push_c(input logic [2:0] v);
    exp_t x;
    x.is_color = 1'b1;
    x.addr     = 32'd0;
    x.data     = {29'b0, v};
    x.memop    = 3'b000;
    sb.push_back(x);
  endfunction

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge wrclk) begin
    if (rst_n === 1'b1 && (bus.wren === 1'b1 || bus.color_wren === 1'b1)) begin
      chk("wren_and_color_wren", 80'({bus.wren, bus.color_wren} == 2'b11), 80'(0));
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_unexpected wren=%b color_wren=%b wraddr=%0h datain=%0h expected=no write",
               bus.wren, bus.color_wren, bus.wraddr, bus.datain);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.is_color)
          chk("sb_color", 80'({bus.color_wren, bus.wren, bus.datain}),
              80'({2'b10, mon_e.data}));
        else
          chk("sb_write", 80'({bus.wren, bus.color_wren, bus.memop, bus.wraddr, bus.datain}),
              80'({2'b10, mon_e.memop, mon_e.addr, mon_e.data}));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge wrclk);
      n++;
    end
    chk("idle_reached", 80'(bus.busy), 80'(0));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge wrclk);
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    @(posedge wrclk);
    #1 bus.char_valid = 1'b0;
  endtask

  task automatic m_newline();
    m_col = 0;
    m_row = (m_row + 1) % 64;
    if (((m_row - m_sl + 64) % 64) == 30) begin
      m_sl = (m_sl + 1) % 64;
      for (int k = 0; k < 70; k++) push_w(m_row * 70 + k, 32'h20, 3'b000);
    end
  endtask

  task automatic tx_print(input logic [7:0] b);
    push_w(m_row * 70 + m_col, {24'b0, b}, 3'b000);
    m_col++;
    if (m_col == 70) m_newline();
    send(b);
    wait_idle(200);
  endtask

  task automatic tx_lf();
    m_newline();
    send(8'h0A);
    wait_idle(200);
  endtask

  task automatic tx_bs();
    if (m_col > 0) begin
      m_col--;
      push_w(m_row * 70 + m_col, 32'h20, 3'b000);
    end
    send(8'h08);
    wait_idle(200);
  endtask

  task automatic push_ff();
    for (int k = 0; k < 1120; k++) push_w(4 * k, 32'h20202020, 3'b010);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge wrclk);
    #1 rst_n = 1'b1;
    m_row = 0; m_col = 0; m_sl = 0;
  endtask

  initial begin
    int nb;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.color_set  = 1'b0;
    bus.color_val  = 3'b000;
    rst_n          = 1'b0;
    repeat (3) @(posedge wrclk);
    #1;
    chk("rst_wren",       80'(bus.wren),       80'(0));
    chk("rst_wraddr",     80'(bus.wraddr),     80'(0));
    chk("rst_datain",     80'(bus.datain),     80'(0));
    chk("rst_memop",      80'(bus.memop),      80'(0));
    chk("rst_color_wren", 80'(bus.color_wren), 80'(0));
    chk("rst_char_ready", 80'(bus.char_ready), 80'(1));
    chk("rst_busy",       80'(bus.busy),       80'(0));
    chk("rst_start_line", 80'(bus.start_line), 80'(0));
    rst_n = 1'b1;

    // 'A' then 'B'; char_ready drops for exactly one cycle.
    push_w(0, 32'h41, 3'b000);
    m_col = 1;
    send(8'h41);
    chk("A_ready_low", 80'(bus.char_ready), 80'(0));
    @(posedge wrclk);
    #1 chk("A_ready_back", 80'(bus.char_ready), 80'(1));
    tx_print(8'h42);
    chk("AB_sb_empty", 80'(sb.size()), 80'(0));

    // Line wrap at column 70.
    do_reset();
    for (int i = 0; i < 70; i++) tx_print(8'h30 + 8'(i % 40));
    tx_print(8'h5A);
    chk("wrap_start_line", 80'(bus.start_line), 80'(0));
    chk("wrap_sb_empty", 80'(sb.size()), 80'(0));

    // 29 LFs: no writes, no scroll.
    do_reset();
    for (int i = 0; i < 29; i++) tx_lf();
    chk("lf29_start_line", 80'(bus.start_line), 80'(0));
    chk("lf29_sb_empty", 80'(sb.size()), 80'(0));

    // 30th LF scrolls: one WR_CHAR cycle plus 70 blank writes.
    m_newline();
    send(8'h0A);
    nb = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge wrclk);
      if (bus.busy !== 1'b1) break;
      nb++;
    end
    chk("scroll_busy_cycles", 80'(nb), 80'(71));
    chk("scroll_start_line", 80'(bus.start_line), 80'(1));
    chk("scroll_sb_empty", 80'(sb.size()), 80'(0));

    // Ring wrap of the cursor row.
    while (m_row != 63) tx_lf();
    tx_lf();
    chk("ringwrap_start_line", 80'(bus.start_line), 80'(35));
    chk("ringwrap_sb_empty", 80'(sb.size()), 80'(0));

    // Backspace at col 0, then "AB" + BS + 'C'.
    tx_bs();
    chk("bs0_sb_empty", 80'(sb.size()), 80'(0));
    tx_print(8'h41);
    tx_print(8'h42);
    tx_bs();
    tx_print(8'h43);
    chk("bs_sb_empty", 80'(sb.size()), 80'(0));

    // Colour write in IDLE.
    push_c(3'b101);
    @(negedge wrclk);
    bus.color_set = 1'b1;
    bus.color_val = 3'b101;
    @(posedge wrclk);
    #1 bus.color_set = 1'b0;
    repeat (3) @(negedge wrclk);
    chk("color_sb_empty", 80'(sb.size()), 80'(0));

    // Colour request colliding with a char accept is dropped.
    push_w(m_row * 70 + m_col, 32'h44, 3'b000);
    m_col++;
    @(negedge wrclk);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h44;
    bus.color_set  = 1'b1;
    bus.color_val  = 3'b011;
    @(posedge wrclk);
    #1;
    bus.char_valid = 1'b0;
    bus.color_set  = 1'b0;
    wait_idle(200);
    repeat (2) @(negedge wrclk);
    chk("collide_sb_empty", 80'(sb.size()), 80'(0));

    // Form feed, with a colour request while busy.
    push_ff();
    m_row = 0; m_col = 0; m_sl = 0;
    send(8'h0C);
    repeat (10) @(negedge wrclk);
    bus.color_set = 1'b1;
    bus.color_val = 3'b111;
    @(posedge wrclk);
    #1 bus.color_set = 1'b0;
    wait_idle(3000);
    chk("ff_start_line", 80'(bus.start_line), 80'(0));
    chk("ff_sb_empty", 80'(sb.size()), 80'(0));
    tx_print(8'h41);
    chk("ff_A_sb_empty", 80'(sb.size()), 80'(0));

    // Scroll twice, then reset in the middle of a full clear.
    for (int i = 0; i < 31; i++) tx_lf();
    chk("pre_abort_start_line", 80'(bus.start_line), 80'(2));
    push_ff();
    send(8'h0C);
    repeat (300) @(negedge wrclk);
    rst_n = 1'b0;
    @(posedge wrclk);
    #1;
    chk("abort_wren",       80'(bus.wren),       80'(0));
    chk("abort_char_ready", 80'(bus.char_ready), 80'(1));
    chk("abort_start_line", 80'(bus.start_line), 80'(0));
    chk("abort_busy",       80'(bus.busy),       80'(0));
    rst_n = 1'b1;
    sb.delete();
    m_row = 0; m_col = 0; m_sl = 0;
    repeat (2) @(negedge wrclk);
    chk("abort_no_more_writes", 80'(bus.wren), 80'(0));
    tx_print(8'h51);
    chk("abort_Q_sb_empty", 80'(sb.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
